// File: rtl/gsim_param.sv
// gsim_param: Gauss-Seidel solver for a fixed symmetric 7-band matrix M*x=b.
// Define GSIM_EARLY_STOP_EN to stop sweeping once max |dx| per sweep <= TOL.
module gsim_param #(
  parameter int N    = 16,
  parameter int ITER = 64,
  parameter int BW   = 16,
  parameter int XW   = 32,
  parameter int TOL  = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_en,
  input  logic [BW-1:0] b_in,
  output logic          out_valid,
  output logic [XW-1:0] x_out,
  output logic          busy
);

  localparam int IW = $clog2(N + 1);
  localparam int NW = XW + 8;
  localparam int PW = NW + 18;

  localparam logic [IW-1:0] LAST    = IW'(N - 1);
  localparam logic [IW-1:0] NUM     = IW'(N);
  localparam logic [7:0]    SW_LAST = 8'(ITER - 1);

  localparam logic signed [NW-1:0] C13   = NW'(13);
  localparam logic signed [NW-1:0] C6    = NW'(6);
  localparam logic signed [PW-1:0] RECIP = PW'(52429);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC,
    OUT
  } state_t;

  state_t               state;
  logic [IW-1:0]        idx;
  logic [7:0]           sweep;
  logic signed [BW-1:0] b_mem [N];
  logic signed [XW-1:0] x_mem [N];

  logic signed [BW-1:0] b_cur;
  logic signed [XW-1:0] x_cur;
  logic signed [XW-1:0] xm [1:3];
  logic signed [XW-1:0] xp [1:3];

  // Neighbour select; out-of-range taps stay zero.
  always_comb begin
    b_cur = '0;
    x_cur = '0;
    for (int d = 1; d <= 3; d++) begin
      xm[d] = '0;
      xp[d] = '0;
    end
    for (int j = 0; j < N; j++) begin
      if (j == int'(idx)) begin
        b_cur = b_mem[j];
        x_cur = x_mem[j];
      end
      for (int d = 1; d <= 3; d++) begin
        if (j == int'(idx) - d) xm[d] = x_mem[j];
        if (j == int'(idx) + d) xp[d] = x_mem[j];
      end
    end
  end

  logic signed [NW-1:0] s1;
  logic signed [NW-1:0] s2;
  logic signed [NW-1:0] s3;
  logic signed [NW-1:0] bs;
  logic signed [NW-1:0] num;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] q;
  logic                 fits;
  logic signed [XW-1:0] x_new;

  // 52429 / 2^20 approximates 1/20; shift floors toward -inf.
  always_comb begin
    s1    = NW'(xm[1]) + NW'(xp[1]);
    s2    = NW'(xm[2]) + NW'(xp[2]);
    s3    = NW'(xm[3]) + NW'(xp[3]);
    bs    = NW'(b_cur) <<< 16;
    num   = bs + C13 * s1 - C6 * s2 + s3;
    prod  = PW'(num) * RECIP;
    q     = prod >>> 20;
    fits  = (&q[PW-1:XW-1]) | ~(|q[PW-1:XW-1]);
    if (fits)
      x_new = q[XW-1:0];
    else if (q[PW-1])
      x_new = {1'b1, {(XW-1){1'b0}}};
    else
      x_new = {1'b0, {(XW-1){1'b1}}};
  end

`ifdef GSIM_EARLY_STOP_EN
  localparam logic [XW:0] TOL_V = (XW+1)'(TOL);

  logic signed [XW:0] diff;
  logic [XW:0]        delta;
  logic [XW:0]        dmax;
  logic [XW:0]        dmax_nx;
  logic               converged;

  always_comb begin
    diff      = (XW+1)'(x_new) - (XW+1)'(x_cur);
    delta     = diff[XW] ? (XW+1)'(-diff) : (XW+1)'(diff);
    dmax_nx   = (delta > dmax) ? delta : dmax;
    converged = (dmax_nx <= TOL_V);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      dmax <= '0;
    else if (state != CALC || idx == LAST)
      dmax <= '0;
    else
      dmax <= dmax_nx;
  end
`else
  logic converged;
  assign converged = 1'b0;
`endif

  assign busy = (state == CALC) || (state == OUT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      sweep     <= '0;
      out_valid <= 1'b0;
      x_out     <= '0;
      for (int j = 0; j < N; j++) begin
        b_mem[j] <= '0;
        x_mem[j] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (in_en) begin
            b_mem[0] <= b_in;
            idx      <= IW'(1);
            state    <= LOAD;
            for (int j = 0; j < N; j++)
              x_mem[j] <= '0;
          end
        end
        LOAD: begin
          if (in_en) begin
            for (int j = 0; j < N; j++)
              if (j == int'(idx)) b_mem[j] <= b_in;
            if (idx == LAST) begin
              idx   <= '0;
              sweep <= '0;
              state <= CALC;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        CALC: begin
          for (int j = 0; j < N; j++)
            if (j == int'(idx)) x_mem[j] <= x_new;
          if (idx == LAST) begin
            idx <= '0;
            if (sweep == SW_LAST || converged)
              state <= OUT;
            else
              sweep <= sweep + 8'd1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        OUT: begin
          if (idx != NUM) begin
            out_valid <= 1'b1;
            x_out     <= x_cur;
            idx       <= idx + 1'b1;
          end else begin
            out_valid <= 1'b0;
            x_out     <= '0;
            idx       <= '0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gsim_param.sv
// tb_gsim_param: directed bench for gsim_param (N=16/ITER=64 and N=4/ITER=255).
// Expected solutions come from an integer Gauss-Seidel reference model.
module tb_gsim_param;

  logic        clk;
  logic        reset;
  logic        in_en;
  logic [15:0] b_in;
  logic        out_valid;
  logic [31:0] x_out;
  logic        busy;
  logic        in_en4;
  logic [15:0] b_in4;
  logic        out_valid4;
  logic [31:0] x_out4;
  logic        busy4;

  gsim_param dut (
    .clk(clk), .reset(reset), .in_en(in_en), .b_in(b_in),
    .out_valid(out_valid), .x_out(x_out), .busy(busy)
  );

  gsim_param #(.N(4), .ITER(255)) dut4 (
    .clk(clk), .reset(reset), .in_en(in_en4), .b_in(b_in4),
    .out_valid(out_valid4), .x_out(x_out4), .busy(busy4)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int k_edge;

  int     mb [64];
  longint mx [64];
  int     pat [16] = '{5, -3, 2, 0, 7, -1, 4, 1, -6, 3, 0, 2, -4, 5, 1, -2};

  logic [31:0] cap [64];
  int          cap_first;
  int          cap_cnt;
  int          cap_idle_bad;
  int          cap_busy_bad;
  logic        cap_after_v;
  logic [31:0] cap_after_x;
  logic        cap_after_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint nb(input int k, input int n);
    if (k < 0 || k >= n) return 0;
    return mx[k];
  endfunction

  function automatic void run_model(input int n, input int iter);
    longint num;
    longint q;
    for (int j = 0; j < 64; j++) mx[j] = 0;
    for (int s = 0; s < iter; s++)
      for (int i = 0; i < n; i++) begin
        num = longint'(mb[i]) * 65536
            + 13 * (nb(i-1, n) + nb(i+1, n))
            - 6 * (nb(i-2, n) + nb(i+2, n))
            + nb(i-3, n) + nb(i+3, n);
        q = (num * 52429) >>> 20;
        if (q > 64'sd2147483647) q = 64'sd2147483647;
        if (q < -64'sd2147483648) q = -64'sd2147483648;
        mx[i] = q;
      end
  endfunction

  task automatic load16(input int gap_after, input bit skip_wait);
    for (int i = 0; i < 16; i++) begin
      if (!(skip_wait && i == 0)) @(negedge clk);
      in_en = 1'b1;
      b_in  = 16'(mb[i]);
      @(posedge clk);
      #1 k_edge = cyc;
      if (i == gap_after) begin
        @(negedge clk);
        in_en = 1'b0;
        repeat (2) @(negedge clk);
      end
    end
    @(negedge clk);
    in_en = 1'b0;
  endtask

  task automatic load4();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_en4 = 1'b1;
      b_in4  = 16'(mb[i]);
      @(posedge clk);
      #1 k_edge = cyc;
    end
    @(negedge clk);
    in_en4 = 1'b0;
  endtask

  task automatic capture(input bit sel);
    int t;
    logic v;
    logic [31:0] xv;
    logic bz;
    t = 0;
    cap_first = -1;
    cap_cnt = 0;
    cap_idle_bad = 0;
    cap_busy_bad = 0;
    forever begin
      v  = sel ? out_valid4 : out_valid;
      xv = sel ? x_out4 : x_out;
      bz = sel ? busy4 : busy;
      if (v === 1'b1 || t >= 5000) break;
      if (xv !== 32'h0) cap_idle_bad++;
      if (bz !== 1'b1) cap_busy_bad++;
      @(negedge clk);
      t++;
    end
    if (v === 1'b1) begin
      cap_first = cyc;
      while (v === 1'b1 && cap_cnt < 64) begin
        cap[cap_cnt] = xv;
        if (bz !== 1'b1) cap_busy_bad++;
        cap_cnt++;
        @(negedge clk);
        v  = sel ? out_valid4 : out_valid;
        xv = sel ? x_out4 : x_out;
        bz = sel ? busy4 : busy;
      end
    end
    cap_after_v = v;
    cap_after_x = xv;
    cap_after_busy = bz;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || x_out !== 32'h0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset16: got v=%b x=%h busy=%b expected 0/0/0",
               out_valid, x_out, busy);
    end
    checks++;
    if (out_valid4 !== 1'b0 || x_out4 !== 32'h0 || busy4 !== 1'b0) begin
      failures++;
      $display("FAIL reset4: got v=%b x=%h busy=%b expected 0/0/0",
               out_valid4, x_out4, busy4);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_zero();
    int exp_first;
    int bad;
    for (int i = 0; i < 16; i++) mb[i] = 0;
    load16(-1, 1'b0);
`ifdef GSIM_EARLY_STOP_EN
    exp_first = k_edge + 17;
`else
    exp_first = k_edge + 1025;
`endif
    capture(1'b0);
    checks++;
    if (cap_first != exp_first) begin
      failures++;
      $display("FAIL zero_latency: got %0d expected %0d", cap_first, exp_first);
    end
    checks++;
    if (cap_cnt != 16) begin
      failures++;
      $display("FAIL zero_count: got %0d expected 16", cap_cnt);
    end
    bad = 0;
    for (int i = 0; i < cap_cnt; i++) if (cap[i] !== 32'h0) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL zero_values: got %0d nonzero expected 0", bad);
    end
    checks++;
    if (cap_idle_bad != 0 || cap_busy_bad != 0) begin
      failures++;
      $display("FAIL zero_idle: got xbad=%0d busybad=%0d expected 0/0",
               cap_idle_bad, cap_busy_bad);
    end
    checks++;
    if (cap_after_v !== 1'b0 || cap_after_x !== 32'h0 || cap_after_busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_after: got v=%b x=%h busy=%b expected 0/0/0",
               cap_after_v, cap_after_x, cap_after_busy);
    end
  endtask

  task automatic test_pattern();
    real err;
    real r;
    real m;
    int xi;
    for (int i = 0; i < 16; i++) mb[i] = pat[i];
    run_model(16, 64);
    load16(-1, 1'b0);
    capture(1'b0);
    checks++;
    if (cap_cnt != 16) begin
      failures++;
      $display("FAIL pat_count: got %0d expected 16", cap_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cap[i] !== 32'(mx[i])) begin
        failures++;
        $display("FAIL pat_x%0d: got %h expected %h", i, cap[i], 32'(mx[i]));
      end
    end
    err = 0.0;
    for (int i = 0; i < 16; i++) begin
      r = -$itor(pat[i]);
      for (int j = 0; j < 16; j++) begin
        case ((i > j) ? i - j : j - i)
          0: m = 20.0;
          1: m = -13.0;
          2: m = 6.0;
          3: m = -1.0;
          default: m = 0.0;
        endcase
        xi = cap[j];
        r = r + m * $itor(xi) / 65536.0;
      end
      err = err + r * r;
    end
    checks++;
    if (!(err < 0.3)) begin
      failures++;
      $display("FAIL pat_residual: got %f expected < 0.3", err);
    end
  endtask

  task automatic test_gap();
    bit lat_ok;
    for (int i = 0; i < 16; i++) mb[i] = pat[i];
    run_model(16, 64);
    load16(5, 1'b0);
    capture(1'b0);
`ifdef GSIM_EARLY_STOP_EN
    lat_ok = cap_first > k_edge && cap_first <= k_edge + 1025;
`else
    lat_ok = cap_first == k_edge + 1025;
`endif
    checks++;
    if (!lat_ok) begin
      failures++;
      $display("FAIL gap_latency: got %0d expected %0d", cap_first, k_edge + 1025);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cap[i] !== 32'(mx[i])) begin
        failures++;
        $display("FAIL gap_x%0d: got %h expected %h", i, cap[i], 32'(mx[i]));
      end
    end
  endtask

  task automatic test_back_to_back();
    bit lat_ok;
    int bad;
    for (int i = 0; i < 16; i++) mb[i] = 0;
    load16(-1, 1'b0);
    capture(1'b0);
    for (int i = 0; i < 16; i++) mb[i] = -pat[15 - i];
    run_model(16, 64);
    load16(-1, 1'b1);
    capture(1'b0);
`ifdef GSIM_EARLY_STOP_EN
    lat_ok = cap_first > k_edge && cap_first <= k_edge + 1025;
`else
    lat_ok = cap_first == k_edge + 1025;
`endif
    checks++;
    if (!lat_ok) begin
      failures++;
      $display("FAIL b2b_latency: got %0d expected %0d", cap_first, k_edge + 1025);
    end
    checks++;
    if (cap_cnt != 16) begin
      failures++;
      $display("FAIL b2b_count: got %0d expected 16", cap_cnt);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) if (cap[i] !== 32'(mx[i])) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL b2b_values: got %0d wrong elements expected 0", bad);
    end
  endtask

  task automatic test_mid_reset();
    int exp_first;
    int bad;
    for (int i = 0; i < 16; i++) mb[i] = pat[i];
    load16(-1, 1'b0);
    repeat (99) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || x_out !== 32'h0) begin
      failures++;
      $display("FAIL midreset_now: got busy=%b v=%b x=%h expected 0/0/0",
               busy, out_valid, x_out);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) mb[i] = 0;
    load16(-1, 1'b0);
`ifdef GSIM_EARLY_STOP_EN
    exp_first = k_edge + 17;
`else
    exp_first = k_edge + 1025;
`endif
    capture(1'b0);
    checks++;
    if (cap_first != exp_first) begin
      failures++;
      $display("FAIL midreset_latency: got %0d expected %0d", cap_first, exp_first);
    end
    bad = 0;
    for (int i = 0; i < cap_cnt; i++) if (cap[i] !== 32'h0) bad++;
    checks++;
    if (bad != 0 || cap_cnt != 16) begin
      failures++;
      $display("FAIL midreset_values: got %0d nonzero of %0d expected 0 of 16",
               bad, cap_cnt);
    end
  endtask

  task automatic test_small();
    bit lat_ok;
    mb[0] = 20;
    mb[1] = 0;
    mb[2] = 0;
    mb[3] = 0;
    run_model(4, 255);
    load4();
    repeat (50) @(negedge clk);
    in_en4 = 1'b1;
    b_in4 = 16'h7fff;
    repeat (20) @(negedge clk);
    in_en4 = 1'b0;
    b_in4 = 16'h0;
    capture(1'b1);
`ifdef GSIM_EARLY_STOP_EN
    lat_ok = cap_first > k_edge && cap_first <= k_edge + 1021;
`else
    lat_ok = cap_first == k_edge + 1021;
`endif
    checks++;
    if (!lat_ok) begin
      failures++;
      $display("FAIL small_latency: got %0d expected %0d", cap_first, k_edge + 1021);
    end
    checks++;
    if (cap_cnt != 4 || cap_after_v !== 1'b0) begin
      failures++;
      $display("FAIL small_count: got %0d expected 4", cap_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap[i] !== 32'(mx[i])) begin
        failures++;
        $display("FAIL small_x%0d: got %h expected %h", i, cap[i], 32'(mx[i]));
      end
    end
    checks++;
    if (cap_busy_bad != 0 || cap_idle_bad != 0) begin
      failures++;
      $display("FAIL small_busy: got busybad=%0d xbad=%0d expected 0/0",
               cap_busy_bad, cap_idle_bad);
    end
  endtask

  initial begin
    reset = 1'b0;
    in_en = 1'b0;
    b_in = 16'h0;
    in_en4 = 1'b0;
    b_in4 = 16'h0;
    test_reset();
    test_zero();
    test_pattern();
    test_gap();
    test_back_to_back();
    test_mid_reset();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
